// File: rtl/instr_length_decoder.sv
// Multi-cycle x86 instruction length decoder. Legacy prefixes are scanned one per cycle,
// then the opcode, ModRM/SIB, displacement and immediate are sized in one CALC cycle.

module opcode_imm_size_detect (
  input  logic [15:0] opcode,
  input  logic        size_prefix,
  output logic [1:0]  opcode_bytes,
  output logic [2:0]  immediete_bytes,
  output logic        have_modrm
);
  logic [7:0] b0_s;
  logic [7:0] b1_s;
  logic [2:0] imm_z_s;

  assign b0_s    = opcode[7:0];
  assign b1_s    = opcode[15:8];
  assign imm_z_s = size_prefix ? 3'd2 : 3'd4;

  // Opcode map lookup; for one-byte opcodes b1 is the ModRM byte (F6/F7 /0,/1 carry an immediate)
  always_comb begin
    opcode_bytes    = 2'd1;
    immediete_bytes = 3'd0;
    have_modrm      = 1'b0;
    if (b0_s == 8'h0F) begin
      opcode_bytes = 2'd2;
      have_modrm   = 1'b1;
      case (b1_s) inside
        [8'h80:8'h8F]: begin have_modrm = 1'b0; immediete_bytes = imm_z_s; end
        [8'h04:8'h0B], 8'h0E, [8'h30:8'h37], 8'h77, [8'hA0:8'hA2], [8'hA8:8'hAA],
        [8'hC8:8'hCF]: have_modrm = 1'b0;
        [8'h70:8'h73], 8'hA4, 8'hAC, 8'hBA, 8'hC2, [8'hC4:8'hC6]: immediete_bytes = 3'd1;
        default: ;
      endcase
    end else begin
      case (b0_s) inside
        [8'h00:8'h3F]: begin
          case (b0_s[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: have_modrm = 1'b1;
            3'd4:    immediete_bytes = 3'd1;
            3'd5:    immediete_bytes = imm_z_s;
            default: ;
          endcase
        end
        8'h69, 8'h81, 8'hC7: begin have_modrm = 1'b1; immediete_bytes = imm_z_s; end
        8'h6B, 8'h80, 8'h82, 8'h83, 8'hC0, 8'hC1, 8'hC6: begin
          have_modrm = 1'b1; immediete_bytes = 3'd1;
        end
        8'h62, 8'h63, [8'h84:8'h8F], 8'hC4, 8'hC5, [8'hD0:8'hD3], [8'hD8:8'hDF],
        8'hFE, 8'hFF: have_modrm = 1'b1;
        8'h68, 8'hA9, [8'hB8:8'hBF], 8'hE8, 8'hE9: immediete_bytes = imm_z_s;
        8'h6A, [8'h70:8'h7F], 8'hA8, [8'hB0:8'hB7], 8'hCD, 8'hD4, 8'hD5, [8'hE0:8'hE7],
        8'hEB: immediete_bytes = 3'd1;
        8'hC2, 8'hCA:  immediete_bytes = 3'd2;
        8'hC8:         immediete_bytes = 3'd3;
        [8'hA0:8'hA3]: immediete_bytes = 3'd4;
        8'h9A, 8'hEA:  immediete_bytes = size_prefix ? 3'd4 : 3'd6;
        8'hF6: begin have_modrm = 1'b1; immediete_bytes = (b1_s[5:4] == 2'b00) ? 3'd1 : 3'd0; end
        8'hF7: begin have_modrm = 1'b1; immediete_bytes = (b1_s[5:4] == 2'b00) ? imm_z_s : 3'd0; end
        default: ;
      endcase
    end
  end
endmodule

module instr_length_decoder #(
  parameter int WINDOW_BYTES = 16,
  parameter int MAX_PREFIXES = 4,
  parameter int LEN_W        = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      window_valid,
  input  logic [WINDOW_BYTES*8-1:0] window_bytes,
  output logic                      window_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LEN_W-1:0]          out_len,
  output logic [2:0]                out_prefix_cnt,
  output logic                      out_opsize,
  output logic                      out_addrsize,
  output logic [1:0]                out_rep,
  output logic [2:0]                out_seg,
  output logic                      out_lock,
  output logic                      out_fault
);
  localparam int IW  = LEN_W + 1;
  localparam int PW  = WINDOW_BYTES * 8 + 32;
  localparam int PIW = $clog2(PW);

  typedef enum logic [1:0] {S_SCAN = 2'd0, S_CALC = 2'd1, S_OUT = 2'd2} state_t;
  typedef struct packed {
    logic       opsize;
    logic       addrsize;
    logic [1:0] rep;
    logic [2:0] seg;
    logic       lock;
  } flags_t;

  state_t           state_r, state_nx_s;
  logic [LEN_W-1:0] ptr_r, ptr_nx_s, out_len_r, out_len_nx_s, len_s;
  flags_t           flags_r, flags_nx_s, oflags_r, oflags_nx_s;
  logic             out_valid_r, out_valid_nx_s, out_fault_r, out_fault_nx_s;
  logic [2:0]       out_cnt_r, out_cnt_nx_s;

  logic [PW-1:0] pad_s;
  logic [IW-1:0] ptr_ext_s, modrm_idx_s, sib_idx_s;
  logic [7:0]    cur_byte_s;
  logic [15:0]   opcode_s;
  logic [1:0]    opc_bytes_s, mod_s;
  logic [2:0]    imm_bytes_s, rm_s, sib_base_s, disp_len_s;
  logic          have_modrm_s, sib_len_s, scan_fault_s;

  function automatic logic [PIW-1:0] bitpos(input logic [IW-1:0] idx, input logic [2:0] off);
    return PIW'({idx, off});
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    case (b)
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic flags_t apply_prefix(input flags_t f, input logic [7:0] b);
    flags_t r;
    r = f;
    case (b)
      8'h66:   r.opsize   = 1'b1;
      8'h67:   r.addrsize = 1'b1;
      8'hF0:   r.lock     = 1'b1;
      8'hF2:   r.rep      = 2'b10;
      8'hF3:   r.rep      = 2'b11;
      8'h26:   r.seg      = 3'd1;
      8'h2E:   r.seg      = 3'd2;
      8'h36:   r.seg      = 3'd3;
      8'h3E:   r.seg      = 3'd4;
      8'h64:   r.seg      = 3'd5;
      8'h65:   r.seg      = 3'd6;
      default: ;
    endcase
    return r;
  endfunction

  // Zero padding lets ModRM/SIB lookups run past the window end without going out of range
  assign pad_s        = {32'h0000_0000, window_bytes};
  assign ptr_ext_s    = {1'b0, ptr_r};
  assign cur_byte_s   = pad_s[bitpos(ptr_ext_s, 3'd0) +: 8];
  assign opcode_s     = pad_s[bitpos(ptr_ext_s, 3'd0) +: 16];
  assign modrm_idx_s  = ptr_ext_s + IW'(opc_bytes_s);
  assign sib_idx_s    = modrm_idx_s + IW'(1);
  assign mod_s        = pad_s[bitpos(modrm_idx_s, 3'd6) +: 2];
  assign rm_s         = pad_s[bitpos(modrm_idx_s, 3'd0) +: 3];
  assign sib_base_s   = pad_s[bitpos(sib_idx_s, 3'd0) +: 3];
  assign scan_fault_s = (ptr_r >= LEN_W'(MAX_PREFIXES)) || (ptr_r >= LEN_W'(WINDOW_BYTES - 1));

  opcode_imm_size_detect u_opc (
    .opcode          (opcode_s),
    .size_prefix     (flags_r.opsize),
    .opcode_bytes    (opc_bytes_s),
    .immediete_bytes (imm_bytes_s),
    .have_modrm      (have_modrm_s)
  );

  // SIB and displacement sizing for 32-bit and 16-bit addressing
  always_comb begin
    sib_len_s  = 1'b0;
    disp_len_s = 3'd0;
    if (!have_modrm_s) begin
      disp_len_s = 3'd0;
    end else if (flags_r.addrsize) begin
      case (mod_s)
        2'b00:   disp_len_s = (rm_s == 3'b110) ? 3'd2 : 3'd0;
        2'b01:   disp_len_s = 3'd1;
        2'b10:   disp_len_s = 3'd2;
        default: disp_len_s = 3'd0;
      endcase
    end else begin
      sib_len_s = (mod_s != 2'b11) && (rm_s == 3'b100);
      case (mod_s)
        2'b00:   disp_len_s = ((rm_s == 3'b101) || (sib_len_s && sib_base_s == 3'b101)) ? 3'd4 : 3'd0;
        2'b01:   disp_len_s = 3'd1;
        2'b10:   disp_len_s = 3'd4;
        default: disp_len_s = 3'd0;
      endcase
    end
  end

  assign len_s = ptr_r + LEN_W'(opc_bytes_s) + LEN_W'(have_modrm_s) + LEN_W'(sib_len_s)
               + LEN_W'(disp_len_s) + LEN_W'(imm_bytes_s);

  // Next-state and next-output logic
  always_comb begin
    state_nx_s     = state_r;
    ptr_nx_s       = ptr_r;
    flags_nx_s     = flags_r;
    oflags_nx_s    = oflags_r;
    out_valid_nx_s = out_valid_r;
    out_fault_nx_s = out_fault_r;
    out_len_nx_s   = out_len_r;
    out_cnt_nx_s   = out_cnt_r;
    case (state_r)
      S_SCAN: begin
        if (!window_valid) begin
          state_nx_s = S_SCAN;
        end else if (!is_prefix(cur_byte_s)) begin
          state_nx_s = S_CALC;
        end else if (scan_fault_s) begin
          state_nx_s     = S_OUT;
          out_valid_nx_s = 1'b1;
          out_fault_nx_s = 1'b1;
          out_len_nx_s   = {LEN_W{1'b0}};
          out_cnt_nx_s   = 3'(ptr_r);
          oflags_nx_s    = flags_r;
        end else begin
          ptr_nx_s   = ptr_r + LEN_W'(1);
          flags_nx_s = apply_prefix(flags_r, cur_byte_s);
        end
      end
      S_CALC: begin
        state_nx_s     = S_OUT;
        out_valid_nx_s = 1'b1;
        out_cnt_nx_s   = 3'(ptr_r);
        oflags_nx_s    = flags_r;
        if (len_s > LEN_W'(WINDOW_BYTES)) begin
          out_fault_nx_s = 1'b1;
          out_len_nx_s   = {LEN_W{1'b0}};
        end else begin
          out_fault_nx_s = 1'b0;
          out_len_nx_s   = len_s;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_nx_s     = S_SCAN;
          ptr_nx_s       = {LEN_W{1'b0}};
          flags_nx_s     = '{default: '0};
          oflags_nx_s    = '{default: '0};
          out_valid_nx_s = 1'b0;
          out_fault_nx_s = 1'b0;
          out_len_nx_s   = {LEN_W{1'b0}};
          out_cnt_nx_s   = 3'd0;
        end else begin
          state_nx_s = S_OUT;
        end
      end
      default: begin
        state_nx_s     = S_SCAN;
        ptr_nx_s       = {LEN_W{1'b0}};
        flags_nx_s     = '{default: '0};
        oflags_nx_s    = '{default: '0};
        out_valid_nx_s = 1'b0;
        out_fault_nx_s = 1'b0;
        out_len_nx_s   = {LEN_W{1'b0}};
        out_cnt_nx_s   = 3'd0;
      end
    endcase
  end

  // State, scan pointer, prefix flags and registered result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_SCAN;
      ptr_r       <= {LEN_W{1'b0}};
      flags_r     <= '{default: '0};
      oflags_r    <= '{default: '0};
      out_valid_r <= 1'b0;
      out_fault_r <= 1'b0;
      out_len_r   <= {LEN_W{1'b0}};
      out_cnt_r   <= 3'd0;
    end else begin
      state_r     <= state_nx_s;
      ptr_r       <= ptr_nx_s;
      flags_r     <= flags_nx_s;
      oflags_r    <= oflags_nx_s;
      out_valid_r <= out_valid_nx_s;
      out_fault_r <= out_fault_nx_s;
      out_len_r   <= out_len_nx_s;
      out_cnt_r   <= out_cnt_nx_s;
    end
  end

  assign window_ready   = out_valid_r & out_ready;
  assign out_valid      = out_valid_r;
  assign out_len        = out_len_r;
  assign out_prefix_cnt = out_cnt_r;
  assign out_opsize     = oflags_r.opsize;
  assign out_addrsize   = oflags_r.addrsize;
  assign out_rep        = oflags_r.rep;
  assign out_seg        = oflags_r.seg;
  assign out_lock       = oflags_r.lock;
  assign out_fault      = out_fault_r;
endmodule

// File: tb/tb_instr_length_decoder.sv
// Directed bench for instr_length_decoder: a 16-byte instance for the main vectors and
// an 8-byte instance for window-overflow boundaries.

module tb_instr_length_decoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         valid16, ready16, ov16, ordy16, ops16, adr16, lock16, flt16;
  logic [127:0] win16;
  logic [4:0]   len16;
  logic [2:0]   cnt16, seg16;
  logic [1:0]   rep16;

  logic         valid8, ready8, ov8, ordy8, ops8, adr8, lock8, flt8;
  logic [63:0]  win8;
  logic [4:0]   len8;
  logic [2:0]   cnt8, seg8;
  logic [1:0]   rep8;

  int    checks = 0;
  int    errors = 0;
  int    pulses16 = 0;
  int    pulses8 = 0;
  int    cyc, p0;
  string cur_case = "init";

  instr_length_decoder #(.WINDOW_BYTES(16), .MAX_PREFIXES(4), .LEN_W(5)) dut16 (
    .clk(clk), .reset(reset), .window_valid(valid16), .window_bytes(win16),
    .window_ready(ready16), .out_valid(ov16), .out_ready(ordy16), .out_len(len16),
    .out_prefix_cnt(cnt16), .out_opsize(ops16), .out_addrsize(adr16), .out_rep(rep16),
    .out_seg(seg16), .out_lock(lock16), .out_fault(flt16)
  );

  instr_length_decoder #(.WINDOW_BYTES(8), .MAX_PREFIXES(4), .LEN_W(5)) dut8 (
    .clk(clk), .reset(reset), .window_valid(valid8), .window_bytes(win8),
    .window_ready(ready8), .out_valid(ov8), .out_ready(ordy8), .out_len(len8),
    .out_prefix_cnt(cnt8), .out_opsize(ops8), .out_addrsize(adr8), .out_rep(rep8),
    .out_seg(seg8), .out_lock(lock8), .out_fault(flt8)
  );

  // Count window_ready pulses per instance
  always @(posedge clk) begin
    if (ready16) pulses16 <= pulses16 + 1;
    if (ready8)  pulses8  <= pulses8 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", cur_case, tag, got, exp);
    end
  endtask

  task automatic check_fields(input int e_len, input int e_cnt, input int e_ops, input int e_adr,
                              input int e_rep, input int e_seg, input int e_lock, input int e_flt);
    chk("len",   32'(len16),  e_len);
    chk("cnt",   32'(cnt16),  e_cnt);
    chk("opsz",  32'(ops16),  e_ops);
    chk("adsz",  32'(adr16),  e_adr);
    chk("rep",   32'(rep16),  e_rep);
    chk("seg",   32'(seg16),  e_seg);
    chk("lock",  32'(lock16), e_lock);
    chk("fault", 32'(flt16),  e_flt);
  endtask

  task automatic run_case(input string name, input logic [127:0] win, input int gap, input int stall,
                          input int e_len, input int e_cnt, input int e_ops, input int e_adr,
                          input int e_rep, input int e_seg, input int e_lock, input int e_flt,
                          input int e_lat);
    int cycles;
    int p;
    cur_case = name;
    @(negedge clk);
    win16 = win; valid16 = 1'b1; ordy16 = 1'b0;
    cycles = 0;
    while (cycles < 40 && !ov16) begin
      @(negedge clk);
      cycles++;
      if (!ov16 && cycles == 1 && gap > 0) begin
        valid16 = 1'b0;
        repeat (gap) begin @(negedge clk); cycles++; end
        valid16 = 1'b1;
      end
    end
    chk("latency", cycles, e_lat);
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      chk("out_valid", 32'(ov16), 32'd1);
      chk("wr_hold", 32'(ready16), 32'd0);
      check_fields(e_len, e_cnt, e_ops, e_adr, e_rep, e_seg, e_lock, e_flt);
    end
    p = pulses16;
    ordy16 = 1'b1; valid16 = 1'b0;
    #1 chk("wr_handshake", 32'(ready16), 32'd1);
    @(negedge clk);
    chk("ov_clear", 32'(ov16), 32'd0);
    chk("len_clear", 32'(len16), 32'd0);
    chk("wr_pulses", pulses16 - p, 32'd1);
    ordy16 = 1'b0;
  endtask

  task automatic run8(input string name, input logic [63:0] win, input int e_len, input int e_flt,
                      input int e_lat);
    int cycles;
    int p;
    cur_case = name;
    @(negedge clk);
    win8 = win; valid8 = 1'b1; ordy8 = 1'b0;
    cycles = 0;
    while (cycles < 40 && !ov8) begin
      @(negedge clk);
      cycles++;
    end
    chk("latency", cycles, e_lat);
    chk("out_valid", 32'(ov8), 32'd1);
    chk("len", 32'(len8), e_len);
    chk("fault", 32'(flt8), e_flt);
    p = pulses8;
    ordy8 = 1'b1; valid8 = 1'b0;
    #1 chk("wr_handshake", 32'(ready8), 32'd1);
    @(negedge clk);
    chk("ov_clear", 32'(ov8), 32'd0);
    chk("wr_pulses", pulses8 - p, 32'd1);
    ordy8 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    valid16 = 1'b0; ordy16 = 1'b0; win16 = 128'h0;
    valid8 = 1'b0;  ordy8 = 1'b0;  win8 = 64'h0;
    #12;
    cur_case = "reset";
    chk("ov16", 32'(ov16), 32'd0);
    chk("len16", 32'(len16), 32'd0);
    chk("wr16", 32'(ready16), 32'd0);
    chk("flt16", 32'(flt16), 32'd0);
    chk("ov8", 32'(ov8), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    //        name          window                         gap stl len cnt ops adr rep seg lck flt lat
    run_case("add_eax",    128'h1234567805,                 0, 0,  5,  0,  0,  0,  0,  0,  0,  0,  2);
    run_case("opsize",     128'h12340566,                   0, 0,  4,  1,  1,  0,  0,  0,  0,  0,  3);
    run_case("sib_disp32", 128'h0000001024848B,             0, 0,  7,  0,  0,  0,  0,  0,  0,  0,  2);
    run_case("rep_cs",     128'h08458B2EF3,                 0, 0,  5,  2,  0,  0,  3,  2,  0,  0,  4);
    run_case("a16_disp8",  128'h08468B67,                   0, 0,  4,  1,  0,  1,  0,  0,  0,  0,  3);
    run_case("two_byte",   128'hC0B60F,                     0, 0,  3,  0,  0,  0,  0,  0,  0,  0,  2);
    run_case("pfx_fault",  128'h906666666666,               0, 0,  0,  4,  1,  0,  0,  0,  0,  1,  5);
    run_case("a16_disp16", 128'h1234068B67,                 0, 0,  5,  1,  0,  1,  0,  0,  0,  0,  3);
    run_case("sib_base5",  128'h1234567825048B,             0, 0,  7,  0,  0,  0,  0,  0,  0,  0,  2);
    run_case("gap_lock",   128'hC801F0F2,                   2, 0,  4,  2,  0,  0,  2,  0,  1,  0,  6);
    run_case("imm16",      128'h1234C08166,                 0, 0,  5,  1,  1,  0,  0,  0,  0,  0,  3);
    run_case("seg_last",   128'h906526,                     0, 0,  3,  2,  0,  0,  0,  6,  0,  0,  4);
    run_case("stall",      128'h1234567805,                 0, 5,  5,  0,  0,  0,  0,  0,  0,  0,  2);

    run8("w8_overflow", 64'h22110000000080C7, 0, 1, 2);
    run8("w8_exact",    64'h0000001024848B3E, 8, 0, 3);

    // Reset while a result is waiting: outputs drop without a clock and no pulse escapes
    cur_case = "reset_out";
    @(negedge clk);
    win16 = 128'h1234567805; valid16 = 1'b1;
    cyc = 0;
    while (cyc < 40 && !ov16) begin @(negedge clk); cyc++; end
    chk("ov_before", 32'(ov16), 32'd1);
    valid16 = 1'b0;
    p0 = pulses16;
    reset = 1'b0;
    #1 chk("ov_async", 32'(ov16), 32'd0);
    chk("len_async", 32'(len16), 32'd0);
    ordy16 = 1'b1;
    #1 chk("wr_in_reset", 32'(ready16), 32'd0);
    @(negedge clk);
    reset = 1'b1; ordy16 = 1'b0;
    @(negedge clk);
    chk("ov_after", 32'(ov16), 32'd0);
    chk("no_pulse", pulses16 - p0, 32'd0);

    // Reset after two prefixes have been scanned; the next decode must start clean
    cur_case = "reset_scan";
    @(negedge clk);
    win16 = 128'h08468B6766; valid16 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("ov_async", 32'(ov16), 32'd0);
    @(negedge clk);
    reset = 1'b1; valid16 = 1'b0;
    run_case("after_reset", 128'h1234567805, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
